// File: rtl/jtag_1149_d10_mstr_rx_err_seq_detector.sv
// Error-sequence detector on the 8b/10b receive path: counts runs of
// ERROR_CHAR K-symbols terminated by IDLE_CHAR.
module jtag_1149_d10_mstr_rx_err_seq_detector #(
  parameter int DATA_WIDTH  = 8,
  parameter int ERR_RUN_LEN = 4,
  parameter int CNT_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] ERROR_CHAR = DATA_WIDTH'(8'hFE),
  parameter logic [DATA_WIDTH-1:0] IDLE_CHAR  = DATA_WIDTH'(8'hBC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] decoded_data,
  input  logic                  decoder_k_out,
  input  logic                  data_valid,
  input  logic                  err_clr,
  output logic                  error_char_detected,
  output logic                  error_sticky,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [3:0]            run_len
);

  localparam logic [3:0] RUN_MAX = 4'(ERR_RUN_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT,
    RUN,
    ARMED
  } state_t;

  state_t state_q, state_d;
  logic [3:0] run_q, run_d;
  logic det_d, det_q;
  logic sticky_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic is_err, is_idl;

  assign is_err = decoder_k_out && (decoded_data == ERROR_CHAR);
  assign is_idl = decoder_k_out && (decoded_data == IDLE_CHAR);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    det_d   = 1'b0;
    if (data_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_err) begin
            run_d   = 4'd1;
            state_d = (RUN_MAX == 4'd1) ? ARMED : RUN;
          end else begin
            run_d = '0;
          end
        end
        RUN: begin
          if (is_err) begin
            run_d = run_q + 4'd1;
            if (run_d == RUN_MAX) state_d = ARMED;
          end else begin
            run_d   = '0;
            state_d = HUNT;
          end
        end
        ARMED: begin
          if (is_err) begin
            run_d = RUN_MAX;
          end else begin
            det_d   = is_idl;
            run_d   = '0;
            state_d = HUNT;
          end
        end
        default: begin
          run_d   = '0;
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      run_q   <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      det_q   <= det_d;
    end
  end

  // A detection in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (det_d) begin
      sticky_q <= 1'b1;
      if (err_clr)
        cnt_q <= CNT_WIDTH'(1);
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (err_clr) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign error_char_detected = det_q;
  assign error_sticky        = sticky_q;
  assign error_count         = cnt_q;
  assign run_len             = run_q;

endmodule

// File: tb/tb_jtag_1149_d10_mstr_rx_err_seq_detector.sv
// Scoreboard bench: directed scenarios plus random symbol streams,
// checked against a run-counting reference model.
module tb_jtag_1149_d10_mstr_rx_err_seq_detector;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] decoded_data = '0;
  logic       decoder_k_out = 1'b0;
  logic       data_valid = 1'b0;
  logic       err_clr = 1'b0;

  logic       det8, sticky8, det2, sticky2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [3:0] rl8, rl2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic p;
    logic s;
    int   c8;
    int   c2;
    int   rl;
  } exp_t;

  exp_t q[$];

  int   m_run = 0;
  logic m_p = 0, m_s = 0;
  int   m_c8 = 0, m_c2 = 0;

  always #5 clk = ~clk;

  jtag_1149_d10_mstr_rx_err_seq_detector dut8 (
    .clk(clk), .rst_n(rst_n),
    .decoded_data(decoded_data), .decoder_k_out(decoder_k_out),
    .data_valid(data_valid), .err_clr(err_clr),
    .error_char_detected(det8), .error_sticky(sticky8),
    .error_count(cnt8), .run_len(rl8)
  );

  jtag_1149_d10_mstr_rx_err_seq_detector #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .decoded_data(decoded_data), .decoder_k_out(decoder_k_out),
    .data_valid(data_valid), .err_clr(err_clr),
    .error_char_detected(det2), .error_sticky(sticky2),
    .error_count(cnt2), .run_len(rl2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: run = consecutive ERR symbols since the last other symbol;
  // an IDL closes a sequence when that run reached L.
  task automatic model(input logic r, input logic v, input logic [7:0] d,
                       input logic k, input logic clr);
    logic err, idl;
    err = v && k && d == 8'hFE;
    idl = v && k && d == 8'hBC;
    if (!r) begin
      m_run = 0; m_p = 0; m_s = 0; m_c8 = 0; m_c2 = 0;
      return;
    end
    m_p = idl && (m_run >= L);
    if (v) m_run = err ? m_run + 1 : 0;
    if (m_p) begin
      m_s  = 1;
      m_c8 = clr ? 1 : (m_c8 < 255 ? m_c8 + 1 : 255);
      m_c2 = clr ? 1 : (m_c2 < 3 ? m_c2 + 1 : 3);
    end else if (clr) begin
      m_s = 0; m_c8 = 0; m_c2 = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic k, input logic clr);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    data_valid = v;
    decoded_data = d;
    decoder_k_out = k;
    err_clr = clr;
    model(r, v, d, k, clr);
    e.p = m_p; e.s = m_s; e.c8 = m_c8; e.c2 = m_c2;
    e.rl = m_run < L ? m_run : L;
    q.push_back(e);
  endtask

  task automatic sym(input logic v, input logic [7:0] d, input logic k,
                     input logic clr);
    step(1'b1, v, d, k, clr);
  endtask

  task automatic fe(input int n);
    for (int i = 0; i < n; i++) sym(1, 8'hFE, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model(0, 0, 0, 0, 0);
    #1;
    chk("async_rst_det", int'(det8), 0);
    chk("async_rst_sticky", int'(sticky8), 0);
    chk("async_rst_cnt", int'(cnt8), 0);
    chk("async_rst_run", int'(rl8), 0);
    step(0, 1, 8'hFE, 1, 0);
    step(0, 1, 8'hBC, 1, 0);
  endtask

  // Monitor: compares each queued expectation just after its clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pulse", int'(det8), int'(e.p));
        chk("pulse_w2", int'(det2), int'(e.p));
        chk("sticky", int'(sticky8), int'(e.s));
        chk("sticky_w2", int'(sticky2), int'(e.s));
        chk("count", int'(cnt8), e.c8);
        chk("count_w2", int'(cnt2), e.c2);
        chk("run_len", int'(rl8), e.rl);
        chk("run_len_w2", int'(rl2), e.rl);
      end
    end
  end

  initial begin
    int r;
    logic [7:0] d;
    logic k, v, c;
    #1;
    chk("init_rst_det", int'(det8), 0);
    chk("init_rst_cnt", int'(cnt8), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    fe(4); sym(1, 8'hBC, 1, 0); sym(0, 0, 0, 0);
    fe(3); sym(1, 8'hBC, 1, 0);
    fe(6); sym(1, 8'hBC, 1, 0);
    fe(2);
    for (int i = 0; i < 5; i++) sym(0, 8'hFE, 1, 0);
    fe(2); sym(1, 8'hBC, 1, 0);
    fe(4); sym(1, 8'hFE, 0, 0); sym(1, 8'hBC, 1, 0);
    fe(4); sym(1, 8'hBC, 0, 0);

    sym(0, 0, 0, 1);
    for (int n = 0; n < 5; n++) begin
      fe(4);
      sym(1, 8'hBC, 1, n == 4);
    end
    fe(4); sym(1, 8'hBC, 1, 0);
    fe(4); sym(1, 8'hBC, 1, 0);
    sym(1, 8'h00, 0, 1);

    fe(3); do_reset(); fe(1); sym(1, 8'hBC, 1, 0);
    fe(4); do_reset(); sym(1, 8'hBC, 1, 0);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      k = 1;
      if (r <= 5) d = 8'hFE;
      else if (r <= 7) d = 8'hBC;
      else if (r == 8) begin d = 8'hFE; k = 0; end
      else begin d = 8'($urandom); k = 1'($urandom); end
      v = $urandom_range(0, 9) < 8;
      c = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 199) == 0) do_reset();
      else sym(v, d, k, c);
    end

    repeat (4) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
